// File: rtl/fir_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_accumulator_if
// Description : Stream-in / result-out handshake bundle for fir_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = WIDTH + 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/fir_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fir_accumulator
// Description : Sums NUM_TAPS signed products per frame and presents the
//               wrapped sum with a sticky signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = WIDTH + 4,
    parameter int NUM_TAPS  = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    fir_accumulator_if.slave      bus,
    output logic                  busy
);
    localparam int               c_CNT_W = $clog2(NUM_TAPS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NUM_TAPS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0]   r_tap_cnt;
    logic                 r_ovf;
    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_sum_ovf;
    logic                 w_load;
    logic                 w_add;

    generate
        if (ACC_WIDTH > WIDTH) begin : g_ext_wide
            assign w_ext = {{(ACC_WIDTH - WIDTH){bus.in_data[WIDTH-1]}}, bus.in_data};
        end else begin : g_ext_same
            assign w_ext = bus.in_data;
        end
    endgenerate

    assign w_sum     = r_acc + w_ext;
    // Signed overflow: operands agree in sign but the wrapped sum does not.
    assign w_sum_ovf = (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                       (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load           = 1'b0;
        w_add            = 1'b0;
        bus.in_ready     = (r_state != S_HOLD);
        bus.out_valid    = (r_state == S_HOLD);
        bus.out_data     = r_acc;
        bus.out_overflow = r_ovf;
        busy             = (r_state == S_ACCUM);
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (bus.in_valid) begin
                        w_add = 1'b1;
                        if (r_tap_cnt == c_LAST) begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_tap_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (clear) begin
            r_tap_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (w_load) begin
            r_acc     <= w_ext;
            r_tap_cnt <= c_ONE;
            r_ovf     <= 1'b0;
        end else if (w_add) begin
            r_acc     <= w_sum;
            r_tap_cnt <= r_tap_cnt + c_ONE;
            if (w_sum_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fir_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_accumulator
// Description : Directed scoreboard bench for two fir_accumulator configs.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_accumulator;
    typedef struct {
        logic [11:0] data;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clear_a;
    logic clear_b;
    logic busy_a;
    logic busy_b;
    int   checks;
    int   errors;
    exp_t sb[$];

    fir_accumulator_if #(.WIDTH(8), .ACC_WIDTH(12)) ifa ();
    fir_accumulator_if #(.WIDTH(8), .ACC_WIDTH(8))  ifb ();

    fir_accumulator #(.WIDTH(8), .ACC_WIDTH(12), .NUM_TAPS(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_a),
        .bus   (ifa.slave),
        .busy  (busy_a)
    );

    fir_accumulator #(.WIDTH(8), .ACC_WIDTH(8), .NUM_TAPS(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_b),
        .bus   (ifb.slave),
        .busy  (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input bit b, input logic v, input logic [7:0] d);
        if (b) begin
            ifb.in_valid = v;
            ifb.in_data  = d;
        end else begin
            ifa.in_valid = v;
            ifa.in_data  = d;
        end
    endtask

    task automatic set_ready(input bit b, input logic r);
        if (b) ifb.out_ready = r;
        else   ifa.out_ready = r;
    endtask

    task automatic sample(input bit b, output logic v, output logic [11:0] d,
                          output logic o, output logic r);
        if (b) begin
            v = ifb.out_valid;
            d = {4'h0, ifb.out_data};
            o = ifb.out_overflow;
            r = ifb.in_ready;
        end else begin
            v = ifa.out_valid;
            d = ifa.out_data;
            o = ifa.out_overflow;
            r = ifa.in_ready;
        end
    endtask

    task automatic send(input bit b, input logic [7:0] d);
        drive(b, 1'b1, d);
        @(posedge clk);
        #1;
        drive(b, 1'b0, 8'h00);
    endtask

    // Result must already be valid one cycle after the last beat; then pop and retire it.
    task automatic collect(input bit b, input string tag);
        exp_t        e;
        logic        v;
        logic [11:0] d;
        logic        o;
        logic        r;
        @(negedge clk);
        sample(b, v, d, o, r);
        chk(32'(v), 1, {tag, ".valid"});
        if (sb.size() == 0) begin
            chk(0, 1, {tag, ".sb_empty"});
        end else begin
            e = sb.pop_front();
            chk(32'(d), 32'(e.data), {tag, ".data"});
            chk(32'(o), 32'(e.ovf), {tag, ".ovf"});
        end
        set_ready(b, 1'b1);
        @(posedge clk);
        #1;
        set_ready(b, 1'b0);
        @(negedge clk);
        sample(b, v, d, o, r);
        chk(32'(v), 0, {tag, ".idle_valid"});
        chk(32'(r), 1, {tag, ".idle_ready"});
    endtask

    initial begin
        logic        v;
        logic [11:0] d;
        logic        o;
        logic        r;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        clear_a = 1'b0;
        clear_b = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        set_ready(1'b0, 1'b0);
        set_ready(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        sample(1'b0, v, d, o, r);
        chk(32'(v), 0, "rst.valid");
        chk(32'(d), 0, "rst.data");
        chk(32'(r), 1, "rst.ready");
        chk(32'(busy_a), 0, "rst.busy");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame 1+2+3+4
        sb.push_back('{data: 12'd10, ovf: 1'b0});
        send(1'b0, 8'd1);
        chk(32'(busy_a), 1, "f1.busy");
        send(1'b0, 8'd2);
        send(1'b0, 8'd3);
        sample(1'b0, v, d, o, r);
        chk(32'(v), 0, "f1.early_valid");
        send(1'b0, 8'd4);
        collect(1'b0, "f1");

        // Most-negative inputs, then mixed signs
        sb.push_back('{data: 12'hE00, ovf: 1'b0});
        repeat (4) send(1'b0, 8'h80);
        collect(1'b0, "neg");
        sb.push_back('{data: 12'd131, ovf: 1'b0});
        send(1'b0, 8'h7F);
        send(1'b0, 8'hFF);
        send(1'b0, 8'h00);
        send(1'b0, 8'd5);
        collect(1'b0, "mix");

        // Narrow accumulator: overflow then clean frame
        sb.push_back('{data: 12'h0C8, ovf: 1'b1});
        send(1'b1, 8'd100);
        send(1'b1, 8'd100);
        collect(1'b1, "ovf");
        sb.push_back('{data: 12'h002, ovf: 1'b0});
        send(1'b1, 8'd1);
        send(1'b1, 8'd1);
        collect(1'b1, "post_ovf");

        // Back-pressure in HOLD with in_valid asserted
        sb.push_back('{data: 12'd100, ovf: 1'b0});
        send(1'b0, 8'd10);
        send(1'b0, 8'd20);
        send(1'b0, 8'd30);
        send(1'b0, 8'd40);
        drive(1'b0, 1'b1, 8'd99);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sample(1'b0, v, d, o, r);
            chk(32'(v), 1, "hold.valid");
            chk(32'(d), 100, "hold.data");
            chk(32'(r), 0, "hold.ready");
        end
        drive(1'b0, 1'b0, 8'h00);
        collect(1'b0, "hold");

        // Clear beats a simultaneous accept
        sb.push_back('{data: 12'd20, ovf: 1'b0});
        send(1'b0, 8'd7);
        send(1'b0, 8'd7);
        chk(32'(busy_a), 1, "clr.busy_pre");
        clear_a = 1'b1;
        drive(1'b0, 1'b1, 8'd9);
        @(posedge clk);
        #1;
        clear_a = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk(32'(busy_a), 0, "clr.busy_post");
        chk(32'(ifa.out_valid), 0, "clr.valid");
        repeat (4) send(1'b0, 8'd5);
        collect(1'b0, "clr");

        // Asynchronous reset mid-frame, between edges
        @(posedge clk);
        #1;
        send(1'b0, 8'd1);
        send(1'b0, 8'd1);
        send(1'b0, 8'd1);
        chk(32'(busy_a), 1, "arst.busy_pre");
        #2;
        rst_n = 1'b0;
        #1;
        sample(1'b0, v, d, o, r);
        chk(32'(v), 0, "arst.valid");
        chk(32'(d), 0, "arst.data");
        chk(32'(o), 0, "arst.ovf");
        chk(32'(r), 1, "arst.ready");
        chk(32'(busy_a), 0, "arst.busy");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{data: 12'd4, ovf: 1'b0});
        repeat (4) send(1'b0, 8'd1);
        collect(1'b0, "arst");

        chk(32'(sb.size()), 0, "sb.drained");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fir_accumulator.md
FIR_ACCUMULATOR -- requirements
Module: fir_accumulator

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 8, the signed input sample/product width.
REQ-002 The parameter list SHALL include ACC_WIDTH, default WIDTH+4, the signed accumulator and result width, constrained to ACC_WIDTH >= WIDTH.
REQ-003 The parameter list SHALL include NUM_TAPS, default 4, the number of products summed per output, constrained to NUM_TAPS >= 2.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-006 Port clear SHALL be an input, 1 bit wide: synchronous abort of the current frame.
REQ-007 Port in_valid SHALL be an input, 1 bit wide: in_data is valid.
REQ-008 Port in_ready SHALL be an output, 1 bit wide: the block accepts in_data this cycle.
REQ-009 Port in_data SHALL be an input, WIDTH bits wide: a signed two's-complement product.
REQ-010 Port out_valid SHALL be an output, 1 bit wide: out_data holds a completed sum.
REQ-011 Port out_ready SHALL be an input, 1 bit wide: the consumer takes out_data.
REQ-012 Port out_data SHALL be an output, ACC_WIDTH bits wide: the signed sum of NUM_TAPS products.
REQ-013 Port out_overflow SHALL be an output, 1 bit wide: sticky signed-overflow flag for the presented frame.
REQ-014 Port busy SHALL be an output, 1 bit wide: a frame is partially accumulated.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, ACCUM and HOLD.
REQ-016 An input beat SHALL be accepted in any cycle where in_valid && in_ready && !clear.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-018 Every input SHALL be sign-extended from WIDTH to ACC_WIDTH before it is added.
REQ-019 An accept in IDLE SHALL load acc with the sign-extended in_data, set tap_cnt to 1, clear ovf, and enter ACCUM.
REQ-020 An accept in ACCUM SHALL set acc to acc + the sign-extended in_data, modulo 2^ACC_WIDTH (wrap, no saturation), and increment tap_cnt.
REQ-021 In ACCUM, ovf SHALL be set when both operands have equal sign and the sum's sign differs; once set it stays set until the next frame start.
REQ-022 The accept that brings tap_cnt to NUM_TAPS SHALL move the FSM to HOLD, with out_valid=1 from the next cycle (latency 1 cycle after the last accepted beat).
REQ-023 In HOLD, out_data and out_overflow SHALL remain stable and out_valid SHALL stay 1 until out_valid && out_ready is seen.
REQ-024 A handshake in HOLD SHALL return the FSM to IDLE on the next cycle; in that cycle out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-025 Cycles with in_valid=0 SHALL leave acc, tap_cnt and the FSM state unchanged (gaps allowed mid-frame).
REQ-026 clear=1 in any state SHALL force IDLE, tap_cnt=0, out_valid=0 and ovf=0 on the next edge, discarding any presented result.
REQ-027 clear=1 SHALL take priority over a simultaneous accept or output handshake.
REQ-028 busy SHALL equal 1 exactly when the FSM is in ACCUM.
REQ-029 tap_cnt SHALL be $clog2(NUM_TAPS+1) bits wide and SHALL never exceed NUM_TAPS.
REQ-030 out_data SHALL reflect acc and out_overflow SHALL reflect ovf whenever out_valid=1; both are don't-care otherwise.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force FSM=IDLE, acc=0, tap_cnt=0, ovf=0, out_valid=0, out_data=0, out_overflow=0 and busy=0, and drive in_ready to 1.
REQ-032 Reset asserted mid-frame or in HOLD SHALL discard all partial or pending results.
REQ-033 After rst_n rises, the first accept SHALL start a new frame as in REQ-019.

Verification
REQ-034 The bench SHALL cover: WIDTH=8, ACC_WIDTH=12, NUM_TAPS=4; inputs 1, 2, 3, 4 on consecutive cycles -> out_valid=1 on the cycle after the 4th beat, out_data=10, out_overflow=0.
REQ-035 The bench SHALL cover: inputs -128, -128, -128, -128 -> out_data=-512 (0xE00), out_overflow=0; then inputs 127, -1, 0, 5 -> out_data=131.
REQ-036 The bench SHALL cover: ACC_WIDTH=8, NUM_TAPS=2; inputs 100, 100 -> out_data=-56 (0xC8), out_overflow=1; the next frame 1, 1 -> out_data=2, out_overflow=0.
REQ-037 The bench SHALL cover: out_ready held 0 for 5 cycles in HOLD -> out_data stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE on the next cycle.
REQ-038 The bench SHALL cover: 2 beats (7, 7), then clear together with in_valid=1 (data 9), then 5, 5, 5, 5 -> the 9 is not accepted and out_data=20.
REQ-039 The bench SHALL cover: rst_n pulsed low between clock edges after 3 beats -> all outputs 0 with no clock edge needed; the following 4 beats of 1 -> out_data=4.
